conv_frame_ctrl: RTL and testbench

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

---
 rtl/conv_ctrl_pkg.sv | 22 ++
 rtl/frame_pos_counter.sv | 42 ++++
 rtl/conv_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_conv_frame_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types for the convolution frame controller.
//   ctrl_state_t : controller state (IDLE, RUN, DRAIN)
//   weight_t     : one signed 3-bit kernel coefficient
//   kernel_t     : 9 coefficients; index 0 = top-left, index 8 = bottom-right
//   KERNEL_GX    : Sobel Gx, the kernel selected out of reset
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  typedef logic signed [2:0] weight_t;
  typedef weight_t [8:0] kernel_t;

  // Listed from index 8 down to index 0: {1,0,-1, 2,0,-2, 1,0,-1}
  localparam kernel_t KERNEL_GX = {3'b001, 3'b000, 3'b111,
                                   3'b010, 3'b000, 3'b110,
                                   3'b001, 3'b000, 3'b111};

endpackage

// File: rtl/frame_pos_counter.sv
// Raster position counter for one side of the convolution datapath.
//   clk_i, reset_i : clock, synchronous active-high reset
//   adv_i          : one pixel transferred this cycle
//   col_o, row_o   : position of the next pixel to transfer
//   last_o         : current position is the final pixel of the frame
module frame_pos_counter #(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 16,
  localparam int unsigned CW = $clog2(width_p),
  localparam int unsigned RW = $clog2(height_p)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_o
);

  logic col_end;

  assign col_end = (col_o == CW'(width_p - 1));
  assign last_o  = col_end && (row_o == RW'(height_p - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_o <= '0;
      row_o <= '0;
    end else if (adv_i) begin
      if (last_o) begin
        col_o <= '0;
        row_o <= '0;
      end else if (col_end) begin
        col_o <= '0;
        row_o <= row_o + RW'(1);
      end else begin
        col_o <= col_o + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame controller around a 3x3 convolution datapath.
//   valid_i/ready_o/data_i                : upstream pixels, raster order
//   conv_valid_o/conv_ready_i/conv_data_o : pixels into the datapath
//   conv_valid_i/conv_ready_o/conv_data_i : signed results from the datapath
//   conv_weights_o                        : active kernel (stable while a frame is in flight)
//   cfg_valid_i/cfg_ready_o/cfg_weights_i : kernel load into a one-deep shadow slot
//   valid_o/ready_i/data_o/last_o         : results with the 2-pixel border cropped
//   frame_done_o                          : one-cycle pulse after a frame fully drains
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned linewidth_px_p = 16,
  parameter int unsigned frame_height_p = 16,
  parameter int unsigned in_width_p     = 2,
  parameter int unsigned out_width_p    = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [in_width_p-1:0]         data_i,
  output logic                          conv_valid_o,
  input  logic                          conv_ready_i,
  output logic [in_width_p-1:0]         conv_data_o,
  input  logic                          conv_valid_i,
  output logic                          conv_ready_o,
  input  logic signed [out_width_p-1:0] conv_data_i,
  output kernel_t                       conv_weights_o,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  kernel_t                       cfg_weights_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic signed [out_width_p-1:0] data_o,
  output logic                          last_o,
  output logic                          frame_done_o
);

  localparam int unsigned CW = $clog2(linewidth_px_p);
  localparam int unsigned RW = $clog2(frame_height_p);

  ctrl_state_t   state, state_n;
  logic          in_adv, in_last;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic          out_adv, out_last, keep;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          frame_end;
  logic          unused_in_pos;
  kernel_t       shadow_w;
  logic          shadow_full, commit, cfg_fire;

  frame_pos_counter #(.width_p(linewidth_px_p), .height_p(frame_height_p)) u_in_pos (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .adv_i  (in_adv),
    .col_o  (in_col),
    .row_o  (in_row),
    .last_o (in_last)
  );

  frame_pos_counter #(.width_p(linewidth_px_p), .height_p(frame_height_p)) u_out_pos (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .adv_i  (out_adv),
    .col_o  (out_col),
    .row_o  (out_row),
    .last_o (out_last)
  );

  // Only the last-pixel flag matters on the input side.
  assign unused_in_pos = ^{in_col, in_row};

  // Input side
  assign ready_o      = (state == RUN) && conv_ready_i;
  assign conv_valid_o = (state == RUN) && valid_i;
  assign conv_data_o  = data_i;
  assign in_adv       = valid_i && ready_o;

  // Output side: border results are swallowed without waiting on ready_i.
  assign keep         = (out_row >= RW'(2)) && (out_col >= CW'(2));
  assign conv_ready_o = keep ? ready_i : 1'b1;
  assign valid_o      = keep && conv_valid_i;
  assign data_o       = conv_data_i;
  assign last_o       = valid_o && out_last;
  assign out_adv      = conv_valid_i && conv_ready_o;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (valid_i) state_n = RUN;
      // A zero-latency datapath can finish both sides in the same cycle.
      RUN:     if (in_adv && in_last) state_n = (out_adv && out_last) ? IDLE : DRAIN;
      DRAIN:   if (out_adv && out_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign frame_end = (state != IDLE) && (state_n == IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      frame_done_o <= frame_end;
    end
  end

  // The shadow slot reopens in the same cycle it commits, so a load waiting
  // on a full slot is captured while the older one moves to the active kernel.
  assign commit      = (state == IDLE) && shadow_full;
  assign cfg_ready_o = !shadow_full || commit;
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      conv_weights_o <= KERNEL_GX;
      shadow_w       <= KERNEL_GX;
      shadow_full    <= 1'b0;
    end else begin
      if (commit) conv_weights_o <= shadow_w;
      if (cfg_fire) begin
        shadow_w    <= cfg_weights_i;
        shadow_full <= 1'b1;
      end else if (commit) begin
        shadow_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
module tb_conv_frame_ctrl;
  import conv_ctrl_pkg::*;

  localparam int LW = 4;
  localparam int FH = 4;
  localparam int NPIX = LW * FH;

  typedef int img_t [NPIX];
  typedef int wvec_t [9];

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic valid_i = 1'b0, ready_o;
  logic [1:0] data_i = '0;
  logic conv_valid_o, conv_ready_i = 1'b1;
  logic [1:0] conv_data_o;
  logic conv_valid_i = 1'b0, conv_ready_o;
  logic signed [31:0] conv_data_i = '0;
  kernel_t conv_weights_o;
  logic cfg_valid_i = 1'b0, cfg_ready_o;
  kernel_t cfg_weights_i = '0;
  logic valid_o, ready_i = 1'b1, last_o, frame_done_o;
  logic signed [31:0] data_o;

  conv_frame_ctrl #(
    .linewidth_px_p(LW), .frame_height_p(FH), .in_width_p(2), .out_width_p(32)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .conv_valid_o(conv_valid_o), .conv_ready_i(conv_ready_i), .conv_data_o(conv_data_o),
    .conv_valid_i(conv_valid_i), .conv_ready_o(conv_ready_o), .conv_data_i(conv_data_i),
    .conv_weights_o(conv_weights_o),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_weights_i(cfg_weights_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (bound expired)", name);
  endtask

  function automatic kernel_t kmake(input wvec_t v);
    kernel_t k;
    for (int i = 0; i < 9; i++) k[i] = weight_t'(v[i]);
    return k;
  endfunction

  function automatic longint conv_at(input img_t img, input kernel_t k, input int r, input int c);
    longint s = 0;
    weight_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        w = k[i*3+j];
        s += longint'(w) * img[(r-2+i)*LW + (c-2+j)];
      end
    return s;
  endfunction

  // kind 0: all ones, 1: pixel index mod 4 (column ramp), 2: row number
  function automatic img_t make_img(input int kind);
    img_t m;
    for (int i = 0; i < NPIX; i++)
      m[i] = (kind == 0) ? 1 : (kind == 1) ? (i % 4) : ((i / LW) % 4);
    return m;
  endfunction

  kernel_t kgx, kgy, k1, k2, cur_k, prev_w;
  kernel_t w_log[$];
  logic signed [63:0] exp_d[$];
  logic exp_l[$];
  logic signed [63:0] rec[$];
  logic signed [63:0] rec_b[$];
  int done_cnt = 0;
  bit in_frame = 1'b0;
  bit stall_en = 1'b0;
  bit prev_last_hs = 1'b0;

  // Expected kept results of one frame, straight from the image and kernel.
  task automatic model_frame(input img_t img, input kernel_t k);
    for (int r = 2; r < FH; r++)
      for (int c = 2; c < LW; c++) begin
        exp_d.push_back(conv_at(img, k, r, c));
        exp_l.push_back((r == FH-1) && (c == LW-1));
      end
  endtask

  // Datapath stand-in: one result per accepted pixel, at least one cycle later.
  // Border positions return junk so a leaked drop shows up in data_o.
  img_t dp_img;
  int dp_cnt = 0;
  longint dp_q[$];
  always @(posedge clk) begin
    if (reset_i) begin
      dp_q.delete();
      dp_cnt = 0;
      conv_valid_i <= 1'b0;
      conv_data_i <= '0;
    end else begin
      if (conv_valid_i && conv_ready_o) void'(dp_q.pop_front());
      if (conv_valid_o && conv_ready_i) begin
        dp_img[dp_cnt] = int'(conv_data_o);
        if ((dp_cnt / LW) >= 2 && (dp_cnt % LW) >= 2)
          dp_q.push_back(conv_at(dp_img, conv_weights_o, dp_cnt / LW, dp_cnt % LW));
        else
          dp_q.push_back(-7 - dp_cnt);
        dp_cnt = (dp_cnt + 1) % NPIX;
      end
      conv_valid_i <= (dp_q.size() > 0);
      conv_data_i <= (dp_q.size() > 0) ? 32'(dp_q[0]) : '0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (stall_en) begin
      ready_i = ($urandom_range(0, 1) == 1);
      conv_ready_i = ($urandom_range(0, 2) != 0);
    end else begin
      ready_i = 1'b1;
      conv_ready_i = 1'b1;
    end
  end

  // Compare process: samples 2 ns before each rising edge.
  initial forever begin
    @(negedge clk);
    #3;
    if (reset_i) begin
      prev_last_hs = 1'b0;
      prev_w = conv_weights_o;
    end else begin
      if (valid_o && ready_i) begin
        if (exp_d.size() == 0) fail_now("unexpected_output");
        else begin
          chk("data_o", data_o, exp_d[0]);
          chk("last_o", last_o, exp_l[0]);
          rec.push_back(data_o);
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
        end
      end
      if (!valid_o) chk("last_o_without_valid", last_o, 0);
      chk("frame_done_o", frame_done_o, prev_last_hs);
      prev_last_hs = valid_o && ready_i && last_o;
      if (conv_valid_o) chk("conv_data_o", conv_data_o, data_i);
      if (!conv_ready_i) chk("ready_o_gated", ready_o, 0);
      if (in_frame) chk("weights_in_frame", conv_weights_o, cur_k);
      if (frame_done_o) begin
        done_cnt++;
        in_frame = 1'b0;
      end
      if (conv_weights_o != prev_w) w_log.push_back(conv_weights_o);
      prev_w = conv_weights_o;
    end
  end

  task automatic send_pixels(input img_t img, input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      @(negedge clk);
      valid_i = 1'b1;
      data_i = 2'(img[i]);
      #1;
      while (!ready_o && guard < 300) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (!ready_o) begin
        fail_now("pixel_accept");
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic cfg_load(input kernel_t k, output int waited);
    @(negedge clk);
    cfg_valid_i = 1'b1;
    cfg_weights_i = k;
    #1;
    waited = 0;
    while (!cfg_ready_o && waited < 400) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!cfg_ready_o) fail_now("cfg_accept");
    @(posedge clk);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) fail_now("frame_done_wait");
  endtask

  // cfg_mode 0: none, 1: one Gy load mid-frame, 2: k1 then k2 back to back
  task automatic run_frame(input int kind, input kernel_t k_model, input bit stall, input int cfg_mode);
    img_t img;
    int base, w1, w2;
    img = make_img(kind);
    model_frame(img, k_model);
    rec.delete();
    w_log.delete();
    base = done_cnt;
    cur_k = k_model;
    stall_en = stall;
    in_frame = 1'b1;
    fork
      send_pixels(img, NPIX);
      begin
        if (cfg_mode != 0) begin
          repeat (6) @(negedge clk);
          if (cfg_mode == 1) begin
            cfg_load(kgy, w1);
            chk("cfg_gy_immediate", w1, 0);
          end else begin
            cfg_load(k1, w1);
            cfg_load(k2, w2);
            chk("cfg_first_immediate", w1, 0);
            chk("cfg_second_stalled", (w2 > 0), 1);
          end
          @(negedge clk);
          cfg_valid_i = 1'b0;
        end
      end
    join
    wait_done(base + 1);
    stall_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("frame_done_count", done_cnt - base, 1);
    chk("kept_count", rec.size(), (LW-2)*(FH-2));
    chk("model_drained", exp_d.size(), 0);
  endtask

  task automatic check_reset_state();
    #3;
    chk("rst_ready_o", ready_o, 0);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_last_o", last_o, 0);
    chk("rst_frame_done_o", frame_done_o, 0);
    chk("rst_conv_valid_o", conv_valid_o, 0);
    chk("rst_cfg_ready_o", cfg_ready_o, 1);
    chk("rst_weights_gx", conv_weights_o, kgx);
  endtask

  initial begin
    kgx = kmake('{-1, 0, 1, -2, 0, 2, -1, 0, 1});
    kgy = kmake('{-1, -2, -1, 0, 0, 0, 1, 2, 1});
    k1  = kmake('{1, 1, 1, 1, 1, 1, 1, 1, 1});
    k2  = kmake('{0, 0, 0, 0, 1, 0, 0, 0, 0});
    cur_k = kgx;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    check_reset_state();

    // all ones under Gx: every kept result is 0
    run_frame(0, kgx, 1'b0, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("ones_gx_%0d", i), rec[i], 0);

    // column ramp under Gx: 2 + 4 + 2 = 8 at every kept position
    run_frame(1, kgx, 1'b0, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("ramp_gx_%0d", i), rec[i], 8);
    rec_b = rec;

    // same frame with random stalls on both ready inputs
    run_frame(1, kgx, 1'b1, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("ramp_stall_%0d", i), rec[i], rec_b[i]);

    // Gy loaded mid-frame: this frame still Gx, Gy active afterwards
    run_frame(1, kgx, 1'b1, 1);
    chk("gy_after_frame", conv_weights_o, kgy);
    chk("gy_single_change", w_log.size(), 1);

    // row ramp under Gy: -4*(r-2) + 4*r = 8
    run_frame(2, kgy, 1'b0, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rows_gy_%0d", i), rec[i], 8);

    // two loads in RUN: applied k1 then k2 after the frame
    run_frame(0, kgy, 1'b1, 2);
    chk("two_loads_changes", w_log.size(), 2);
    chk("two_loads_first", w_log[0], k1);
    chk("two_loads_second", w_log[1], k2);

    // centre-tap kernel passes pixel (r-1,c-1): column ramp gives 1,2,1,2
    run_frame(1, k2, 1'b0, 0);
    chk("centre_0", rec[0], 1);
    chk("centre_1", rec[1], 2);
    chk("centre_2", rec[2], 1);
    chk("centre_3", rec[3], 2);

    // reset after 7 pixels of a frame
    cur_k = k2;
    in_frame = 1'b1;
    send_pixels(make_img(1), 7);
    in_frame = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    exp_d.delete();
    exp_l.delete();
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    check_reset_state();
    run_frame(1, kgx, 1'b1, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("post_reset_%0d", i), rec[i], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
